// File: rtl/cnt_mon_pkg.sv
// Shared event types, entry layout and MSB-class decode for the counter event monitor.
package cnt_mon_pkg;

  localparam int         MAX_W    = 15;
  localparam logic [3:0] CLS_ZERO = 4'hF;

  typedef enum logic [1:0] {
    EVT_NONE   = 2'b00,
    EVT_WRAP   = 2'b01,
    EVT_STALL  = 2'b10,
    EVT_OCTAVE = 2'b11
  } evt_t;

  // Value field is sized for the widest legal counter; narrower tops zero-extend.
  typedef struct packed {
    evt_t             etype;
    logic [3:0]       cls;
    logic [MAX_W-1:0] value;
  } evt_entry_t;

  // Index of the highest set bit; the last match in the upward scan has priority.
  function automatic logic [3:0] msb_class(input logic [MAX_W-1:0] v);
    msb_class = CLS_ZERO;
    for (int i = 0; i < MAX_W; i++)
      if (v[i]) msb_class = 4'(i);
  endfunction

endpackage

// File: rtl/cnt_mon_fifo.sv
// Synchronous FIFO with extra-bit pointers; a pop frees a slot for a same-cycle push when full.
module cnt_mon_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]  wr_ptr, rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         wr_en, rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/cnt_event_monitor.sv
// Samples the free-running counter, classifies WRAP/OCTAVE/STALL transitions and queues them.
module cnt_event_monitor
  import cnt_mon_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int STALL_LIMIT = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             en,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [1:0]       evt_type,
  output logic [WIDTH-1:0] evt_value,
  output logic [3:0]       evt_class,
  output logic [7:0]       wrap_cnt,
  output logic [7:0]       drop_cnt
);

  localparam int EW = $bits(evt_entry_t);

  logic [WIDTH-1:0] prev_q;
  logic             prev_vld;
  logic [7:0]       run_q;
  logic [3:0]       cls_in, cls_prev;
  logic             same, is_wrap, is_oct, is_stall, push, pop, full, empty;
  evt_entry_t       push_e, head;
  logic [EW-1:0]    head_raw;

  assign cls_in   = msb_class(MAX_W'(cnt_in));
  assign cls_prev = msb_class(MAX_W'(prev_q));
  assign same     = (cnt_in == prev_q);

  // Priority WRAP > OCTAVE > STALL; STALL needs equal values so it never overlaps the others.
  assign is_wrap  = en & prev_vld & (cnt_in < prev_q);
  assign is_oct   = en & prev_vld & ~is_wrap & (cls_in != cls_prev);
  assign is_stall = en & prev_vld & same & (({1'b0, run_q} + 9'd1) == 9'(STALL_LIMIT));
  assign push     = is_wrap | is_oct | is_stall;
  assign pop      = evt_valid & evt_ready;

  always_comb begin
    push_e.etype = is_wrap ? EVT_WRAP : (is_oct ? EVT_OCTAVE : EVT_STALL);
    push_e.cls   = cls_in;
    push_e.value = MAX_W'(cnt_in);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      prev_q   <= '0;
      prev_vld <= 1'b0;
      run_q    <= '0;
      wrap_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (en) begin
        prev_q   <= cnt_in;
        prev_vld <= 1'b1;
        if (prev_vld && same) begin
          if (run_q != 8'hFF) run_q <= run_q + 8'd1;
        end else begin
          run_q <= '0;
        end
      end
      if (is_wrap && wrap_cnt != 8'hFF) wrap_cnt <= wrap_cnt + 8'd1;
      if (push && full && !pop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  cnt_mon_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_fifo (
    .clk   (CLK),
    .rst_n (RST),
    .push  (push),
    .pop   (pop),
    .din   (push_e),
    .dout  (head_raw),
    .full  (full),
    .empty (empty)
  );

  assign head      = evt_entry_t'(head_raw);
  assign evt_valid = ~empty;
  assign evt_type  = head.etype;
  assign evt_class = head.cls;
  assign evt_value = head.value[WIDTH-1:0];

  if (WIDTH < MAX_W) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^head.value[MAX_W-1:WIDTH];
  end

endmodule

// File: tb/tb_cnt_event_monitor.sv
// Directed bench: ramp, wrap, stall, overflow, full push+pop, async reset and counter saturation.
module tb_cnt_event_monitor;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] cnt_in = '0;
  logic       en = 1'b0;
  logic       evt_ready = 1'b0;
  logic       evt_valid;
  logic [1:0] evt_type;
  logic [7:0] evt_value;
  logic [3:0] evt_class;
  logic [7:0] wrap_cnt, drop_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] t;
    logic [7:0] v;
    logic [3:0] c;
  } ev_t;
  ev_t q[$];

  localparam logic [1:0] T_WRAP = 2'b01, T_STALL = 2'b10, T_OCT = 2'b11;

  cnt_event_monitor dut (
    .CLK(CLK), .RST(RST), .cnt_in(cnt_in), .en(en),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_type(evt_type),
    .evt_value(evt_value), .evt_class(evt_class),
    .wrap_cnt(wrap_cnt), .drop_cnt(drop_cnt)
  );

  always #5 CLK = ~CLK;

  // Entries that will be popped on the coming rising edge.
  always @(negedge CLK)
    if (RST && evt_valid && evt_ready) q.push_back('{evt_type, evt_value, evt_class});

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic chk_q(input string tag, input int i, input logic [1:0] t,
                       input logic [7:0] v, input logic [3:0] c);
    ev_t e;
    e = (i < q.size()) ? q[i] : 14'h3FFF;
    chk({tag, "_ent"}, {18'd0, e}, {18'd0, t, v, c});
  endtask

  task automatic smp(input logic [7:0] v);
    cnt_in = v;
    en     = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic idle(input int n);
    en = 1'b0;
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  initial begin
    #12;
    chk("rst_valid", evt_valid, 0);
    chk("rst_type",  evt_type, 0);
    chk("rst_value", evt_value, 0);
    chk("rst_class", evt_class, 0);
    chk("rst_wrap",  wrap_cnt, 0);
    chk("rst_drop",  drop_cnt, 0);
    RST = 1'b1;
    @(posedge CLK); #1;

    // Ramp 0x00..0x10
    evt_ready = 1'b1;
    smp(8'h00);
    chk("ramp_first", evt_valid, 0);
    smp(8'h01);
    chk("lat_valid", evt_valid, 1);
    chk("lat_value", evt_value, 8'h01);
    for (int v = 2; v <= 16; v++) smp(8'(v));
    idle(3);
    chk("ramp_cnt", q.size(), 5);
    chk_q("ramp0", 0, T_OCT, 8'h01, 4'd0);
    chk_q("ramp1", 1, T_OCT, 8'h02, 4'd1);
    chk_q("ramp2", 2, T_OCT, 8'h04, 4'd2);
    chk_q("ramp3", 3, T_OCT, 8'h08, 4'd3);
    chk_q("ramp4", 4, T_OCT, 8'h10, 4'd4);
    q.delete();

    // Wrap: 0x10->0xFE is an octave change, 0xFE->0xFF nothing, 0xFF->0x00 wraps
    smp(8'hFE); smp(8'hFF); smp(8'h00);
    idle(3);
    chk("wrap_qcnt", q.size(), 2);
    chk_q("wrap_oct", 0, T_OCT, 8'hFE, 4'd7);
    chk_q("wrap_ev", 1, T_WRAP, 8'h00, 4'hF);
    chk("wrap_cnt1", wrap_cnt, 1);
    q.delete();

    // Stall: 7x 0x05, then 5x 0x06
    for (int i = 0; i < 7; i++) begin
      smp(8'h05);
      if (i == 4) chk("stall5_type", evt_type, T_STALL);
    end
    for (int i = 0; i < 5; i++) begin
      smp(8'h06);
      if (i == 4) chk("stall6_type", evt_type, T_STALL);
    end
    idle(3);
    chk("stall_qcnt", q.size(), 3);
    chk_q("stall_oct", 0, T_OCT, 8'h05, 4'd2);
    chk_q("stall_a", 1, T_STALL, 8'h05, 4'd2);
    chk_q("stall_b", 2, T_STALL, 8'h06, 4'd2);
    q.delete();

    // Overflow: six events, only four fit
    evt_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin smp(8'h80); smp(8'h01); end
    chk("ovf_drop", drop_cnt, 2);
    chk("ovf_wrap", wrap_cnt, 4);
    chk("ovf_valid", evt_valid, 1);
    idle(2);
    chk("hold_type",  evt_type, T_OCT);
    chk("hold_value", evt_value, 8'h80);
    chk("hold_class", evt_class, 4'd7);

    // Full push+pop in the same cycle
    evt_ready = 1'b1;
    smp(8'h40);
    evt_ready = 1'b0;
    chk("fpp_drop", drop_cnt, 2);
    chk("fpp_head", evt_value, 8'h01);
    evt_ready = 1'b1;
    idle(6);
    chk("drain_cnt", q.size(), 5);
    chk_q("drain0", 0, T_OCT,  8'h80, 4'd7);
    chk_q("drain1", 1, T_WRAP, 8'h01, 4'd0);
    chk_q("drain2", 2, T_OCT,  8'h80, 4'd7);
    chk_q("drain3", 3, T_WRAP, 8'h01, 4'd0);
    chk_q("drain4", 4, T_OCT,  8'h40, 4'd6);
    chk("drain_valid", evt_valid, 0);
    q.delete();

    // Async reset with the FIFO full
    evt_ready = 1'b0;
    smp(8'h01); smp(8'h80); smp(8'h01); smp(8'h80);
    en = 1'b0;
    chk("pre_rst_valid", evt_valid, 1);
    chk("pre_rst_wrap", wrap_cnt, 6);
    #2 RST = 1'b0;
    #1;
    chk("arst_valid", evt_valid, 0);
    chk("arst_wrap",  wrap_cnt, 0);
    chk("arst_drop",  drop_cnt, 0);
    chk("arst_type",  evt_type, 0);
    chk("arst_value", evt_value, 0);
    #2 RST = 1'b1;
    smp(8'h05);
    chk("post_rst_first", evt_valid, 0);
    smp(8'h90);
    chk("post_rst_valid", evt_valid, 1);
    chk("post_rst_value", evt_value, 8'h90);

    // Saturation of both counters
    for (int i = 0; i < 300; i++) begin smp(8'h01); smp(8'h80); end
    chk("sat_wrap", wrap_cnt, 8'hFF);
    chk("sat_drop", drop_cnt, 8'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
